gate_pulser: RTL and testbench

GATE_PULSER -- requirements
Module: gate_pulser

---
 rtl/gate_pkg.sv | 27 ++
 rtl/gate_tick_div.sv | 34 +++
 rtl/gate_pulser.sv | 228 ++++++++++++++++++++++
 tb/tb_gate_pulser.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared definitions for the gate pulser: FSM states, register map, CTRL/STATUS bits.
package gate_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARM  = 3'd1,
    ST_HIGH = 3'd2,
    ST_LOW  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [7:0] REG_CTRL     = 8'h30;
  localparam logic [7:0] REG_WIDTH    = 8'h31;
  localparam logic [7:0] REG_PERIOD   = 8'h32;
  localparam logic [7:0] REG_COUNT    = 8'h33;
  localparam logic [7:0] REG_STATUS   = 8'h34;
  localparam logic [7:0] REG_PRESCALE = 8'h35;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_ABORT  = 1;
  localparam int unsigned CTRL_CONT   = 2;

  localparam int unsigned STAT_BUSY   = 0;
  localparam int unsigned STAT_DONE   = 1;
  localparam int unsigned STAT_SELERR = 2;

endpackage

// File: rtl/gate_tick_div.sv
// Prescaler: one tick every (prescale_i+1) clocks, phase restarted by restart_i.
module gate_tick_div #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic                  restart_i,
  input  logic [DATA_WIDTH-1:0] prescale_i,
  output logic                  tick_c
);

  logic [DATA_WIDTH-1:0] div_q, div_d;

  // >= so that lowering the prescale below the running count still wraps promptly
  assign tick_c = (div_q >= prescale_i);

  // Divider next count
  always_comb begin
    div_d = div_q + DATA_WIDTH'(1);
    if (restart_i || tick_c) begin
      div_d = '0;
    end
  end

  // Divider register
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/gate_pulser.sv
// Register-programmed one-hot gate pulse train generator.
// Optional GATE_PULSER_PRESCALE_EN adds a PRESCALE register and gate_tick_div prescaler.
module gate_pulser
  import gate_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SEL_WIDTH  = 4,
  parameter int unsigned OUT_GATES  = 10
) (
  input  logic                  clk,
  input  logic                  res_n,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  we,
  input  logic [SEL_WIDTH-1:0]  sel,
  input  logic                  trig,
  output logic [OUT_GATES-1:0]  gates,
  output logic                  busy,
  output logic                  done
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] width_q, period_q, count_q;
  logic                  cont_q, trig_q;
  logic [DATA_WIDTH-1:0] span_q, span_d, pulses_q, pulses_d;
  logic [SEL_WIDTH-1:0]  sel_lat_q, sel_lat_d;
  logic [DATA_WIDTH-1:0] wid_lat_q, wid_lat_d, per_lat_q, per_lat_d, cnt_lat_q, cnt_lat_d;
  logic                  sel_err_q, sel_err_d, done_sticky_q, done_sticky_d;
  logic [OUT_GATES-1:0]  gates_q;
  logic                  busy_q, done_q;
  logic [DATA_WIDTH-1:0] data_out_q, rdata_c;
  logic                  ctrl_wr_c, abort_c, trig_rise_c, start_c, sel_ok_c, tick_c;
  logic [OUT_GATES-1:0]  onehot_c;

  // Phase length minus one; a programmed 0 behaves as 1
  function automatic logic [DATA_WIDTH-1:0] span_m1(input logic [DATA_WIDTH-1:0] v);
    return (v == '0) ? '0 : v - DATA_WIDTH'(1);
  endfunction

  assign ctrl_wr_c   = we && (addr == DATA_WIDTH'(REG_CTRL));
  assign abort_c     = ctrl_wr_c && data_in[CTRL_ABORT];
  assign trig_rise_c = trig && !trig_q;
  assign start_c     = ((ctrl_wr_c && data_in[CTRL_START]) || trig_rise_c) && !abort_c;
  assign sel_ok_c    = (sel != '0) && (32'(sel) <= OUT_GATES);
  assign onehot_c    = OUT_GATES'(1) << (sel_lat_q - SEL_WIDTH'(1));

`ifdef GATE_PULSER_PRESCALE_EN
  logic [DATA_WIDTH-1:0] prescale_q;
  logic                  div_restart_c;

  assign div_restart_c = (state_q == ST_ARM);

  gate_tick_div #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tick_div (
    .clk        (clk),
    .res_n      (res_n),
    .restart_i  (div_restart_c),
    .prescale_i (prescale_q),
    .tick_c     (tick_c)
  );
`else
  assign tick_c = 1'b1;
`endif

  // Programmable registers and trig edge history (trig_q resets high so a held trig never starts)
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      width_q    <= '0;
      period_q   <= '0;
      count_q    <= '0;
      cont_q     <= 1'b0;
      trig_q     <= 1'b1;
`ifdef GATE_PULSER_PRESCALE_EN
      prescale_q <= '0;
`endif
    end else begin
      trig_q <= trig;
      if (we) begin
        case (addr)
          DATA_WIDTH'(REG_CTRL):     cont_q     <= data_in[CTRL_CONT];
          DATA_WIDTH'(REG_WIDTH):    width_q    <= data_in;
          DATA_WIDTH'(REG_PERIOD):   period_q   <= data_in;
          DATA_WIDTH'(REG_COUNT):    count_q    <= data_in;
`ifdef GATE_PULSER_PRESCALE_EN
          DATA_WIDTH'(REG_PRESCALE): prescale_q <= data_in;
`endif
          default: ;
        endcase
      end
    end
  end

  // Read mux; start/abort strobes are never stored so they read back 0
  always_comb begin
    rdata_c = '0;
    case (addr)
      DATA_WIDTH'(REG_CTRL):     rdata_c[CTRL_CONT] = cont_q;
      DATA_WIDTH'(REG_WIDTH):    rdata_c = width_q;
      DATA_WIDTH'(REG_PERIOD):   rdata_c = period_q;
      DATA_WIDTH'(REG_COUNT):    rdata_c = count_q;
      DATA_WIDTH'(REG_STATUS): begin
        rdata_c[STAT_BUSY]   = busy_q;
        rdata_c[STAT_DONE]   = done_sticky_q;
        rdata_c[STAT_SELERR] = sel_err_q;
      end
`ifdef GATE_PULSER_PRESCALE_EN
      DATA_WIDTH'(REG_PRESCALE): rdata_c = prescale_q;
`endif
      default: ;
    endcase
  end

  // Pulse train sequencing: next state, phase counter, latched train parameters
  always_comb begin
    state_d       = state_q;
    span_d        = span_q;
    pulses_d      = pulses_q;
    sel_lat_d     = sel_lat_q;
    wid_lat_d     = wid_lat_q;
    per_lat_d     = per_lat_q;
    cnt_lat_d     = cnt_lat_q;
    sel_err_d     = sel_err_q;
    done_sticky_d = done_sticky_q;
    if (abort_c && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_c) begin
            if (sel_ok_c) begin
              state_d       = ST_ARM;
              sel_lat_d     = sel;
              wid_lat_d     = width_q;
              per_lat_d     = period_q;
              cnt_lat_d     = count_q;
              pulses_d      = '0;
              sel_err_d     = 1'b0;
              done_sticky_d = 1'b0;
            end else begin
              sel_err_d = 1'b1;
            end
          end
        end
        ST_ARM: begin
          if (cnt_lat_q == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_HIGH;
            span_d  = span_m1(wid_lat_q);
          end
        end
        ST_HIGH: begin
          if (tick_c) begin
            if (span_q == '0) begin
              state_d = ST_LOW;
              span_d  = span_m1(per_lat_q);
              if (pulses_q != '1) begin
                pulses_d = pulses_q + DATA_WIDTH'(1);
              end
            end else begin
              span_d = span_q - DATA_WIDTH'(1);
            end
          end
        end
        ST_LOW: begin
          if (tick_c) begin
            if (span_q == '0) begin
              if (cont_q || (pulses_q < cnt_lat_q)) begin
                state_d = ST_HIGH;
                span_d  = span_m1(wid_lat_q);
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              span_d = span_q - DATA_WIDTH'(1);
            end
          end
        end
        ST_DONE: begin
          state_d       = ST_IDLE;
          done_sticky_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, train context and registered outputs
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q       <= ST_IDLE;
      span_q        <= '0;
      pulses_q      <= '0;
      sel_lat_q     <= '0;
      wid_lat_q     <= '0;
      per_lat_q     <= '0;
      cnt_lat_q     <= '0;
      sel_err_q     <= 1'b0;
      done_sticky_q <= 1'b0;
      gates_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      data_out_q    <= '0;
    end else begin
      state_q       <= state_d;
      span_q        <= span_d;
      pulses_q      <= pulses_d;
      sel_lat_q     <= sel_lat_d;
      wid_lat_q     <= wid_lat_d;
      per_lat_q     <= per_lat_d;
      cnt_lat_q     <= cnt_lat_d;
      sel_err_q     <= sel_err_d;
      done_sticky_q <= done_sticky_d;
      gates_q       <= (state_d == ST_HIGH) ? onehot_c : '0;
      busy_q        <= (state_d != ST_IDLE);
      done_q        <= (state_d == ST_DONE);
      data_out_q    <= rdata_c;
    end
  end

  assign gates    = gates_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_gate_pulser.sv
// Bench for gate_pulser: timeline reference model checked every cycle, directed scenarios
// pinned with literal expectations, then randomized register/trig traffic.
module tb_gate_pulser;

  logic       clk;
  logic       res_n;
  logic [7:0] addr, data_in, data_out;
  logic       we, trig, busy, done;
  logic [3:0] sel;
  logic [9:0] gates;

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gate_pulser #(
    .DATA_WIDTH (8),
    .SEL_WIDTH  (4),
    .OUT_GATES  (10)
  ) dut (
    .clk      (clk),
    .res_n    (res_n),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .we       (we),
    .sel      (sel),
    .trig     (trig),
    .gates    (gates),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: a train is a timeline counted from its start ----------------
  int   m_w, m_p, m_c, m_pre;
  bit   m_cont, m_sticky, m_selerr, m_trig_prev;
  bit   m_active, m_in_done;
  int   m_k, m_pstart, m_np, l_sel, l_w, l_p, l_c;
  logic [9:0] e_gates;
  logic [7:0] e_dout;
  bit   e_busy, e_done;

  function automatic int hi_len();
    return ((l_w == 0) ? 1 : l_w) * (m_pre + 1);
  endfunction

  function automatic int lo_len();
    return ((l_p == 0) ? 1 : l_p) * (m_pre + 1);
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] a);
    case (a)
      8'h30:   return {5'd0, m_cont, 2'd0};
      8'h31:   return 8'(m_w);
      8'h32:   return 8'(m_p);
      8'h33:   return 8'(m_c);
      8'h34:   return {5'd0, m_selerr, m_sticky, m_active};
`ifdef GATE_PULSER_PRESCALE_EN
      8'h35:   return 8'(m_pre);
`endif
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step();
    logic [7:0] rd;
    bit ctrl_wr, ab, tr, st;
    if (!res_n) begin
      m_w = 0; m_p = 0; m_c = 0; m_pre = 0; m_cont = 0;
      m_sticky = 0; m_selerr = 0; m_trig_prev = 1;
      m_active = 0; m_in_done = 0;
      e_gates = '0; e_busy = 0; e_done = 0; e_dout = '0;
    end else begin
      rd      = model_read(addr);
      ctrl_wr = we && (addr == 8'h30);
      ab      = ctrl_wr && data_in[1];
      tr      = trig && !m_trig_prev;
      m_trig_prev = trig;
      st      = ((ctrl_wr && data_in[0]) || tr) && !ab;
      if (m_active) begin
        if (ab) begin
          m_active = 0; m_in_done = 0;
        end else if (m_in_done) begin
          m_active = 0; m_in_done = 0; m_sticky = 1;
        end else begin
          m_k++;
          if (m_k == 2) begin
            if (l_c == 0) m_in_done = 1;
            else m_pstart = 2;
          end else begin
            if (m_k - m_pstart == hi_len()) m_np++;
            if (m_k - m_pstart == hi_len() + lo_len()) begin
              if (m_cont || (m_np < l_c)) m_pstart = m_k;
              else m_in_done = 1;
            end
          end
        end
      end else if (st) begin
        if (sel >= 4'd1 && sel <= 4'd10) begin
          l_sel = int'(sel); l_w = m_w; l_p = m_p; l_c = m_c;
          m_active = 1; m_in_done = 0; m_k = 1; m_np = 0;
          m_selerr = 0; m_sticky = 0;
        end else begin
          m_selerr = 1;
        end
      end
      if (we) begin
        case (addr)
          8'h30: m_cont = data_in[2];
          8'h31: m_w = int'(data_in);
          8'h32: m_p = int'(data_in);
          8'h33: m_c = int'(data_in);
`ifdef GATE_PULSER_PRESCALE_EN
          8'h35: m_pre = int'(data_in);
`endif
          default: ;
        endcase
      end
      e_dout  = rd;
      e_busy  = m_active;
      e_done  = m_active && m_in_done;
      e_gates = (m_active && !m_in_done && m_k >= 2 && (m_k - m_pstart) < hi_len())
                ? (10'(1) << (l_sel - 1)) : 10'd0;
    end
  endtask

  // Advance the model on each edge and compare all outputs just after it
  always @(posedge clk) begin
    model_step();
    #1;
    check("model_gates", 32'(gates), 32'(e_gates));
    check("model_busy", 32'(busy), 32'(e_busy));
    check("model_done", 32'(done), 32'(e_done));
    check("model_data_out", 32'(data_out), 32'(e_dout));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    we = 1'b1; addr = a; data_in = d;
    tick();
    we = 1'b0; addr = 8'h00; data_in = 8'h00;
  endtask

  task automatic rd_check(input string name, input logic [7:0] a, input logic [7:0] exp);
    addr = a;
    tick();
    check(name, 32'(data_out), 32'(exp));
    addr = 8'h00;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone, nhigh;
    logic [9:0] exp_g;
    res_n = 1'b1; we = 1'b0; addr = 8'h00; data_in = 8'h00; sel = 4'd0; trig = 1'b0;
    #2 res_n = 1'b0;
    repeat (3) tick();
    check("reset_gates", 32'(gates), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_data_out", 32'(data_out), 32'd0);
    res_n = 1'b1;
    tick();

    // Two pulses of width 4, period 2 on gate 3
    sel = 4'd3;
    wr(8'h31, 8'd4); wr(8'h32, 8'd2); wr(8'h33, 8'd2);
    wr(8'h30, 8'h01);
    ndone = 0;
    for (int n = 1; n <= 16; n++) begin
      exp_g = ((n >= 2 && n <= 5) || (n >= 8 && n <= 11)) ? 10'h004 : 10'h000;
      check("basic_gates", 32'(gates), 32'(exp_g));
      check("basic_busy", 32'(busy), (n <= 14) ? 32'd1 : 32'd0);
      if (done) ndone++;
      tick();
    end
    check("basic_done_count", 32'(ndone), 32'd1);
    rd_check("basic_status", 8'h34, 8'h02);

    // Out-of-range gate number: no activity, sel_err set
    sel = 4'd11;
    wr(8'h30, 8'h01);
    for (int n = 1; n <= 6; n++) begin
      check("selerr_gates", 32'(gates), 32'd0);
      check("selerr_busy", 32'(busy), 32'd0);
      tick();
    end
    addr = 8'h34;
    tick();
    check("selerr_status_bit2", 32'(data_out[2]), 32'd1);
    check("selerr_status_bit0", 32'(data_out[0]), 32'd0);

    // Continuous mode ignores COUNT; abort during the 4th pulse
    sel = 4'd5;
    wr(8'h31, 8'd2); wr(8'h32, 8'd3); wr(8'h33, 8'd1);
    wr(8'h30, 8'h05);
    for (int n = 1; n <= 16; n++) begin
      exp_g = (n >= 2 && ((n - 2) % 5) < 2) ? 10'h010 : 10'h000;
      check("cont_gates", 32'(gates), 32'(exp_g));
      tick();
    end
    check("cont_4th_pulse", 32'(gates), 32'h010);
    wr(8'h30, 8'h03);
    check("abort_gates", 32'(gates), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    ndone = 0;
    for (int n = 0; n < 6; n++) begin
      if (done || busy) ndone++;
      tick();
    end
    check("abort_quiet", 32'(ndone), 32'd0);

    // COUNT=0: ARM then DONE, no pulse
    sel = 4'd2;
    wr(8'h33, 8'd0);
    wr(8'h30, 8'h01);
    for (int n = 1; n <= 6; n++) begin
      check("count0_busy", 32'(busy), (n <= 2) ? 32'd1 : 32'd0);
      check("count0_done", 32'(done), (n == 2) ? 32'd1 : 32'd0);
      check("count0_gates", 32'(gates), 32'd0);
      tick();
    end

    // trig rising edge starts a train: gate up two cycles later
    sel = 4'd4;
    wr(8'h31, 8'd1); wr(8'h33, 8'd1);
    trig = 1'b1;
    tick();
    check("trig_busy", 32'(busy), 32'd1);
    tick();
    check("trig_gates", 32'(gates), 32'h008);
    repeat (6) tick();
    trig = 1'b0;
    tick();

    // Reset in the middle of HIGH, trig held high across release
    sel = 4'd7;
    wr(8'h31, 8'd6); wr(8'h33, 8'd3);
    wr(8'h30, 8'h01);
    tick(); tick();
    check("midreset_pre_gates", 32'(gates), 32'h040);
    #1 res_n = 1'b0; trig = 1'b1;
    #1;
    check("midreset_gates", 32'(gates), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_data_out", 32'(data_out), 32'd0);
    repeat (3) tick();
    res_n = 1'b1;
    for (int a = 8'h30; a <= 8'h35; a++) begin
      rd_check("postreset_reg", 8'(a), 8'h00);
      check("postreset_busy", 32'(busy), 32'd0);
    end
    trig = 1'b0;
    tick();

`ifdef GATE_PULSER_PRESCALE_EN
    // Prescale 1 doubles the width: WIDTH=3 gives 6 high cycles
    sel = 4'd1;
    wr(8'h35, 8'd1); wr(8'h31, 8'd3); wr(8'h32, 8'd1); wr(8'h33, 8'd1);
    wr(8'h30, 8'h01);
    nhigh = 0;
    for (int n = 0; n < 20; n++) begin
      if (gates[0]) nhigh++;
      tick();
    end
    check("prescale_width", 32'(nhigh), 32'd6);
    wr(8'h35, 8'd0);
`else
    nhigh = 0;
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int r;
      we = ($urandom_range(0, 99) < 30);
      r  = $urandom_range(0, 99);
      if (r < 40)      addr = 8'h30;
      else if (r < 55) addr = 8'h31;
      else if (r < 70) addr = 8'h32;
      else if (r < 82) addr = 8'h33;
      else if (r < 90) addr = 8'h34;
      else             addr = 8'($urandom_range(0, 255));
`ifdef GATE_PULSER_PRESCALE_EN
      if (we && addr == 8'h35) addr = 8'h36;
`endif
      if (addr == 8'h30) begin
        data_in = {5'd0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 2) != 0)};
      end else if (addr == 8'h33) begin
        data_in = 8'($urandom_range(0, 4));
      end else begin
        data_in = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255))
                                               : 8'($urandom_range(0, 5));
        if (we && (addr == 8'h31 || addr == 8'h32) && data_in > 8'd20) data_in = 8'd20;
      end
      sel = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 10));
      if ($urandom_range(0, 9) == 0) trig = ~trig;
      if ($urandom_range(0, 999) == 0) begin
        res_n = 1'b0;
        tick();
        res_n = 1'b1;
      end
      tick();
    end
    we = 1'b0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
